// File: rtl/rob.sv
// Reorder buffer: allocates tags in program order, captures CDB results and
// retires one entry per cycle to the register file, store unit or flush logic.
module rob #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_NUM_WIDTH  = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,

    input  logic                      dec_valid,
    input  logic [1:0]                dec_type,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic                      dec_pred_taken,
    input  logic [31:0]               dec_alt_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail,

    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic                      cdb_taken,

    input  logic [ROB_SIZE_WIDTH-1:0] query_tag,
    output logic                      query_ready,
    output logic [31:0]               query_value,

    output logic                      rob_valid,
    output logic [REG_NUM_WIDTH-1:0]  rob_rd,
    output logic [31:0]               rob_value,
    output logic [ROB_SIZE_WIDTH-1:0] rob_dependency,
    output logic                      store_commit,
    output logic                      need_flush_out,
    output logic [31:0]               flush_pc_out
);

    localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_CNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;

    logic [ROB_SIZE_WIDTH-1:0] r_head;
    logic [ROB_SIZE_WIDTH-1:0] r_tail;
    logic [ROB_SIZE_WIDTH:0]   r_count;
    logic [DEPTH-1:0]          r_busy;
    logic [DEPTH-1:0]          r_ready;

    logic [1:0]                r_type     [DEPTH];
    logic [REG_NUM_WIDTH-1:0]  r_rd       [DEPTH];
    logic [31:0]               r_value    [DEPTH];
    logic                      r_pred     [DEPTH];
    logic                      r_taken    [DEPTH];
    logic [31:0]               r_alt_pc   [DEPTH];

    logic       w_full;
    logic       w_issue;
    logic       w_wb;
    logic       w_commit;
    logic       w_mispred;
    logic [1:0] w_dec_type;
    logic [1:0] w_head_type;

    assign w_full      = (r_count == FULL_CNT);
    assign w_issue     = dec_valid && !w_full && !need_flush_out;
    assign w_wb        = cdb_valid && r_busy[cdb_tag];
    assign w_commit    = (r_count != '0) && r_ready[r_head];
    assign w_head_type = r_type[r_head];
    assign w_mispred   = w_commit && (w_head_type == T_BRANCH) &&
                         (r_taken[r_head] != r_pred[r_head]);
    // The reserved type behaves exactly like a register write.
    assign w_dec_type  = (dec_type == 2'd3) ? T_REG : dec_type;

    assign rob_full    = w_full;
    assign rob_tail    = r_tail;
    assign query_ready = r_ready[query_tag] || (cdb_valid && (cdb_tag == query_tag));
    assign query_value = (cdb_valid && (cdb_tag == query_tag)) ? cdb_value : r_value[query_tag];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_busy         <= '0;
            r_ready        <= '0;
            rob_valid      <= 1'b0;
            rob_rd         <= '0;
            rob_value      <= '0;
            rob_dependency <= '0;
            store_commit   <= 1'b0;
            need_flush_out <= 1'b0;
            flush_pc_out   <= '0;
        end else if (rdy_in) begin
            rob_valid      <= 1'b0;
            store_commit   <= 1'b0;
            need_flush_out <= 1'b0;
            if (w_mispred) begin
                // A mispredict squashes everything younger, including a same-cycle issue.
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
                r_busy         <= '0;
                need_flush_out <= 1'b1;
                flush_pc_out   <= r_alt_pc[r_head];
            end else begin
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + 1'b1;
                end
                if (w_wb) begin
                    r_ready[cdb_tag] <= 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                    if (w_head_type == T_REG) begin
                        rob_valid      <= 1'b1;
                        rob_rd         <= r_rd[r_head];
                        rob_value      <= r_value[r_head];
                        rob_dependency <= r_head;
                    end else if (w_head_type == T_STORE) begin
                        store_commit <= 1'b1;
                    end
                end
                case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (w_issue && !w_mispred) begin
                r_type[r_tail]   <= w_dec_type;
                r_rd[r_tail]     <= dec_rd;
                r_pred[r_tail]   <= dec_pred_taken;
                r_alt_pc[r_tail] <= dec_alt_pc;
            end
            if (w_wb) begin
                r_value[cdb_tag] <= cdb_value;
                r_taken[cdb_tag] <= cdb_taken;
            end
        end
    end

endmodule
